ibpl_in6_filter: RTL and testbench

Six-channel input cardlet plugin for the interbackplane frontend. It is the receive-side counterpart to the output/empty cardlet plugins: it leaves all backplane drivers tristated and accepts the six cardlet lines. Each line is synchronized and glitch-filtered, then presented on `internal_in`. Static-level and activity LEDs are driven per channel, and `plugin_error` is raised when the host configures any channel as an output on this input-only cardlet.

---
 rtl/ibpl_pkg.sv | 15 +
 rtl/ibpl_in_channel.sv | 67 ++++++
 rtl/ibpl_in6_filter.sv | 57 +++++
 tb/tb_ibpl_in6_filter.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ibpl_pkg.sv
// Shared constants and types for the interbackplane input cardlet plugin.
package ibpl_pkg;

  localparam int         IBPL_CHANNELS = 6;
  localparam int         IBPL_PORT_W   = 8;
  localparam logic [7:0] IBPL_CH_MASK  = 8'h3F;

  typedef logic [5:0] ibpl_ch_t;

  // True when any of the six physical channels is requested in a port-wide vector.
  function automatic logic ibpl_any_ch(input logic [IBPL_PORT_W-1:0] v);
    return |(v & IBPL_CH_MASK);
  endfunction

endpackage

// File: rtl/ibpl_in_channel.sv
// One cardlet input line: two-flop synchronizer, stable-level glitch filter
// and activity-LED pulse stretcher.
module ibpl_in_channel #(
  parameter int FILTER_CYCLES      = 16,
  parameter int LED_STRETCH_CYCLES = 1250000
) (
  input  logic clk_sys,
  input  logic rstn_sys,
  input  logic din,
  input  logic en,
  output logic level,
  output logic activity
);

  localparam int CNT_W = $clog2(FILTER_CYCLES + 1);
  localparam int ST_W  = $clog2(LED_STRETCH_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER_CYCLES - 1);
  localparam logic [ST_W-1:0]  ST_LOAD  = ST_W'(LED_STRETCH_CYCLES);

  function automatic logic [ST_W-1:0] sat_dec(input logic [ST_W-1:0] v);
    return (v == '0) ? '0 : v - ST_W'(1);
  endfunction

  logic             sync_p0;
  logic             sync_p1;
  logic             filt_p2;
  logic [CNT_W-1:0] cnt_p2;
  logic             edge_p2;
  logic [ST_W-1:0]  st_p3;

  assign edge_p2 = (sync_p1 != filt_p2) && (cnt_p2 == CNT_LAST);

  always_ff @(posedge clk_sys) begin
    if (!rstn_sys) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
      filt_p2 <= 1'b0;
      cnt_p2  <= '0;
      st_p3   <= '0;
    end else begin
      // p0/p1: metastability chain
      sync_p0 <= din;
      sync_p1 <= sync_p0;
      // p2: a candidate level must hold unbroken for the full window
      if (sync_p1 == filt_p2) begin
        cnt_p2 <= '0;
      end else if (edge_p2) begin
        filt_p2 <= ~filt_p2;
        cnt_p2  <= '0;
      end else begin
        cnt_p2 <= cnt_p2 + CNT_W'(1);
      end
      // p3: stretch restarts on every accepted edge, cleared while disabled
      if (!en) begin
        st_p3 <= '0;
      end else if (edge_p2) begin
        st_p3 <= ST_LOAD;
      end else begin
        st_p3 <= sat_dec(st_p3);
      end
    end
  end

  assign level    = filt_p2 & en;
  assign activity = (st_p3 != '0) & en;

endmodule

// File: rtl/ibpl_in6_filter.sv
// Six-channel input cardlet plugin: backplane drivers held as inputs, lines
// filtered onto internal_in with level/activity LEDs and a config error flag.
module ibpl_in6_filter
  import ibpl_pkg::*;
#(
  parameter int FILTER_CYCLES      = 16,
  parameter int LED_STRETCH_CYCLES = 1250000
) (
  input  logic       clk_sys,
  input  logic       rstn_sys,
  input  logic [5:0] diob_in,
  input  logic [7:0] input_enable,
  input  logic [7:0] output_enable,
  output logic [5:0] diob_dir,
  output logic [5:0] diob_out,
  output logic [7:0] internal_in,
  output logic [7:0] diob_led1,
  output logic [7:0] diob_led2,
  output logic       plugin_error
);

  ibpl_ch_t ch_en;
  ibpl_ch_t ch_level;
  ibpl_ch_t ch_activity;

  assign ch_en = ibpl_ch_t'(input_enable & IBPL_CH_MASK);

  for (genvar i = 0; i < IBPL_CHANNELS; i++) begin : g_ch
    ibpl_in_channel #(
      .FILTER_CYCLES     (FILTER_CYCLES),
      .LED_STRETCH_CYCLES(LED_STRETCH_CYCLES)
    ) u_ch (
      .clk_sys  (clk_sys),
      .rstn_sys (rstn_sys),
      .din      (diob_in[i]),
      .en       (ch_en[i]),
      .level    (ch_level[i]),
      .activity (ch_activity[i])
    );
  end

  assign diob_dir    = '0;
  assign diob_out    = '0;
  assign internal_in = IBPL_PORT_W'(ch_level);
  assign diob_led1   = IBPL_PORT_W'(ch_level);
  assign diob_led2   = IBPL_PORT_W'(ch_activity);

  // An input-only cardlet cannot honour any output request on its channels.
  always_ff @(posedge clk_sys) begin
    if (!rstn_sys) begin
      plugin_error <= 1'b0;
    end else begin
      plugin_error <= ibpl_any_ch(output_enable);
    end
  end

endmodule

// File: tb/tb_ibpl_in6_filter.sv
// Bench for ibpl_in6_filter: directed scenarios plus randomized traffic
// against a behavioural model of the filter/stretch rules.
module tb_ibpl_in6_filter;

  localparam int FC = 4;
  localparam int LS = 8;

  logic       clk_sys = 1'b0;
  logic       rstn_sys;
  logic [5:0] diob_in;
  logic [7:0] input_enable;
  logic [7:0] output_enable;
  logic [5:0] diob_dir;
  logic [5:0] diob_out;
  logic [7:0] internal_in;
  logic [7:0] diob_led1;
  logic [7:0] diob_led2;
  logic       plugin_error;

  int checks = 0;
  int errors = 0;

  ibpl_in6_filter #(
    .FILTER_CYCLES     (FC),
    .LED_STRETCH_CYCLES(LS)
  ) dut (
    .clk_sys      (clk_sys),
    .rstn_sys     (rstn_sys),
    .diob_in      (diob_in),
    .input_enable (input_enable),
    .output_enable(output_enable),
    .diob_dir     (diob_dir),
    .diob_out     (diob_out),
    .internal_in  (internal_in),
    .diob_led1    (diob_led1),
    .diob_led2    (diob_led2),
    .plugin_error (plugin_error)
  );

  always #5 clk_sys = ~clk_sys;

  // Reference model: line seen two samples late, level accepted after FC
  // consecutive samples of the new value, activity lit for LS cycles after
  // the latest accepted edge unless the channel was disabled meanwhile.
  logic [5:0] m_hist1, m_hist2, m_f, m_last_s, m_act;
  int         m_run[6];
  int         m_since[6];
  logic       m_err;

  task automatic model_step();
    logic [5:0] s;
    logic       tog;
    if (!rstn_sys) begin
      m_hist1 = '0; m_hist2 = '0; m_f = '0; m_last_s = '0; m_act = '0; m_err = 1'b0;
      for (int i = 0; i < 6; i++) begin
        m_run[i] = 0;
        m_since[i] = 0;
      end
    end else begin
      s = m_hist2;
      for (int i = 0; i < 6; i++) begin
        m_run[i] = (s[i] == m_last_s[i]) ? m_run[i] + 1 : 1;
        m_last_s[i] = s[i];
        tog = (s[i] != m_f[i]) && (m_run[i] >= FC);
        if (tog) m_f[i] = s[i];
        if (!input_enable[i]) begin
          m_act[i] = 1'b0;
        end else if (tog) begin
          m_act[i] = 1'b1;
          m_since[i] = 0;
        end else if (m_act[i]) begin
          m_since[i] = m_since[i] + 1;
          if (m_since[i] >= LS) m_act[i] = 1'b0;
        end
      end
      m_hist2 = m_hist1;
      m_hist1 = diob_in;
      m_err = |output_enable[5:0];
    end
  endtask

  task automatic tick();
    @(posedge clk_sys);
    model_step();
    @(negedge clk_sys);
  endtask

  task automatic do_reset(input logic [5:0] d);
    rstn_sys = 1'b0;
    diob_in = d;
    tick();
    tick();
    rstn_sys = 1'b1;
  endtask

  task automatic test_reset();
    logic [36:0] got;
    logic [7:0]  e_int, e_led2;
    rstn_sys = 1'b0;
    diob_in = 6'h3F;
    input_enable = 8'hFF;
    output_enable = 8'h00;
    for (int k = 0; k < 3; k++) begin
      tick();
      got = {internal_in, diob_led1, diob_led2, plugin_error, diob_dir, diob_out};
      checks++;
      if (got !== 37'h0) begin
        errors++;
        $display("FAIL reset_hold cycle %0d: got %h required 0", k, got);
      end
    end
    rstn_sys = 1'b1;
    for (int k = 1; k <= 15; k++) begin
      tick();
      e_int  = (k >= 6) ? 8'h3F : 8'h00;
      e_led2 = (k >= 6 && k <= 13) ? 8'h3F : 8'h00;
      checks++;
      if ({internal_in, diob_led1, diob_led2} !== {e_int, e_int, e_led2}) begin
        errors++;
        $display("FAIL reset_release k=%0d: int/led1/led2 %h %h %h required %h %h %h",
                 k, internal_in, diob_led1, diob_led2, e_int, e_int, e_led2);
      end
    end
  endtask

  task automatic test_step();
    logic [7:0] e_int, e_led2;
    do_reset(6'h00);
    for (int k = 0; k < 4; k++) tick();
    diob_in = 6'h01;
    for (int k = 1; k <= 16; k++) begin
      tick();
      e_int  = (k >= 6) ? 8'h01 : 8'h00;
      e_led2 = (k >= 6 && k <= 13) ? 8'h01 : 8'h00;
      checks++;
      if ({internal_in, diob_led1, diob_led2} !== {e_int, e_int, e_led2}) begin
        errors++;
        $display("FAIL step_ch0 k=%0d: int/led1/led2 %h %h %h required %h %h %h",
                 k, internal_in, diob_led1, diob_led2, e_int, e_int, e_led2);
      end
    end
  endtask

  task automatic test_glitch();
    logic [7:0] e_int, e_led2;
    do_reset(6'h00);
    for (int k = 0; k < 4; k++) tick();
    for (int k = 1; k <= 12; k++) begin
      diob_in = (k <= 3) ? 6'h02 : 6'h00;
      tick();
      checks++;
      if ({internal_in, diob_led1, diob_led2} !== 24'h0) begin
        errors++;
        $display("FAIL glitch3 k=%0d: int/led1/led2 %h %h %h required 0",
                 k, internal_in, diob_led1, diob_led2);
      end
    end
    for (int k = 1; k <= 20; k++) begin
      diob_in = (k <= 4) ? 6'h02 : 6'h00;
      tick();
      e_int  = (k >= 6 && k <= 9) ? 8'h02 : 8'h00;
      e_led2 = (k >= 6 && k <= 17) ? 8'h02 : 8'h00;
      checks++;
      if ({internal_in, diob_led1, diob_led2} !== {e_int, e_int, e_led2}) begin
        errors++;
        $display("FAIL pulse4 k=%0d: int/led1/led2 %h %h %h required %h %h %h",
                 k, internal_in, diob_led1, diob_led2, e_int, e_int, e_led2);
      end
    end
  endtask

  task automatic test_retrigger();
    logic [7:0] e_int, e_led2;
    do_reset(6'h00);
    for (int k = 0; k < 4; k++) tick();
    for (int k = 1; k <= 24; k++) begin
      diob_in = (k <= 5) ? 6'h04 : 6'h00;
      tick();
      e_int  = (k >= 6 && k <= 10) ? 8'h04 : 8'h00;
      e_led2 = (k >= 6 && k <= 18) ? 8'h04 : 8'h00;
      checks++;
      if ({internal_in, diob_led2} !== {e_int, e_led2}) begin
        errors++;
        $display("FAIL retrigger k=%0d: int/led2 %h %h required %h %h",
                 k, internal_in, diob_led2, e_int, e_led2);
      end
    end
  endtask

  task automatic test_gating();
    do_reset(6'h00);
    input_enable = 8'hF7;
    tick();
    diob_in = 6'h08;
    for (int k = 1; k <= 12; k++) begin
      tick();
      checks++;
      if ({internal_in, diob_led1, diob_led2} !== 24'h0) begin
        errors++;
        $display("FAIL gated_off k=%0d: int/led1/led2 %h %h %h required 0",
                 k, internal_in, diob_led1, diob_led2);
      end
    end
    input_enable = 8'hFF;
    #1;
    checks++;
    if ({internal_in, diob_led1, diob_led2} !== {8'h08, 8'h08, 8'h00}) begin
      errors++;
      $display("FAIL gate_on_same_cycle: int/led1/led2 %h %h %h required 08 08 00",
               internal_in, diob_led1, diob_led2);
    end
    for (int k = 1; k <= 4; k++) begin
      tick();
      checks++;
      if ({internal_in, diob_led2} !== {8'h08, 8'h00}) begin
        errors++;
        $display("FAIL gate_on k=%0d: int/led2 %h %h required 08 00", k, internal_in, diob_led2);
      end
    end
  endtask

  task automatic test_error();
    logic [7:0] oe_seq[5] = '{8'h01, 8'hC0, 8'h20, 8'hFF, 8'h00};
    logic       err_seq[5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    logic       prev;
    prev = plugin_error;
    for (int k = 0; k < 5; k++) begin
      output_enable = oe_seq[k];
      #1;
      checks++;
      if (plugin_error !== prev) begin
        errors++;
        $display("FAIL error_latency oe=%h: got %b required %b", oe_seq[k], plugin_error, prev);
      end
      tick();
      checks++;
      if ({plugin_error, diob_dir, diob_out} !== {err_seq[k], 12'h000}) begin
        errors++;
        $display("FAIL error oe=%h: err/dir/out %b %h %h required %b 00 00",
                 oe_seq[k], plugin_error, diob_dir, diob_out, err_seq[k]);
      end
      prev = err_seq[k];
    end
  endtask

  task automatic test_random();
    logic [36:0] got, exp;
    do_reset(6'h00);
    for (int k = 0; k < 600; k++) begin
      for (int i = 0; i < 6; i++)
        if ($urandom_range(0, 5) == 0) diob_in[i] = ~diob_in[i];
      if ($urandom_range(0, 19) == 0) input_enable = 8'($urandom());
      if ($urandom_range(0, 9) == 0) output_enable = 8'($urandom()) & 8'hC1;
      rstn_sys = ($urandom_range(0, 99) != 0);
      #1;
      got = {internal_in, diob_led1, diob_led2, plugin_error, diob_dir, diob_out};
      exp = {2'b00, m_f & input_enable[5:0], 2'b00, m_f & input_enable[5:0],
             2'b00, m_act & input_enable[5:0], m_err, 12'h000};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL random cycle %0d: outputs %h required %h", k, got, exp);
      end
      tick();
    end
  endtask

  initial begin
    rstn_sys = 1'b0;
    diob_in = '0;
    input_enable = 8'hFF;
    output_enable = 8'h00;
    @(negedge clk_sys);
    test_reset();
    test_step();
    test_glitch();
    test_retrigger();
    test_gating();
    test_error();
    input_enable = 8'hFF;
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
